// File: rtl/ninjin_axi_rd_dma_if.sv
// ninjin_axi_rd_dma_if
// AXI4 read-address and read-data channels between the ninjin read DMA
// (master) and the m_axi_image port (slave).
//   AR: arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
//       arqos, arvalid (master->slave), arready (slave->master)
//   R : rid, rdata, rresp, rlast, rvalid (slave->master),
//       rready (master->slave)
interface ninjin_axi_rd_dma_if #(
  parameter int ID_WIDTH   = 1,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arqos;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/ninjin_axi_rd_dma.sv
// ninjin_axi_rd_dma
// AXI4 burst read master copying total_len contiguous words from DDR into
// a local buffer. The transfer is split into bursts of at most BURST_MAX
// beats with up to OUTSTANDING bursts in flight.
// Ports:
//   clk, xrst            clock, asynchronous active-low reset
//   start                request pulse (ignored while busy)
//   base_addr/total_len/buf_base  transfer description, latched on start
//   busy, done, err      status (done is a one-cycle pulse, err is sticky)
//   buf_we/buf_addr/buf_wdata     local buffer write port
//   m_axi                AXI4 AR/R channels (master modport)
// Optional build macro:
//   NINJIN_RD_4K_SPLIT_EN  limit each burst so it never crosses a 4 KiB
//                          address boundary
module ninjin_axi_rd_dma #(
  parameter int ID_WIDTH      = 1,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int BURST_MAX     = 256,
  parameter int LEN_WIDTH     = 16,
  parameter int BUFADDR_WIDTH = 12,
  parameter int OUTSTANDING   = 2
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [LEN_WIDTH-1:0]     total_len,
  input  logic [BUFADDR_WIDTH-1:0] buf_base,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     buf_we,
  output logic [BUFADDR_WIDTH-1:0] buf_addr,
  output logic [DATA_WIDTH-1:0]    buf_wdata,
  ninjin_axi_rd_dma_if.master      m_axi
);
  localparam int SIZE  = $clog2(DATA_WIDTH / 8);
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_INFL  = CNT_W'(OUTSTANDING);
  localparam logic [31:0]      BURST_CAP = 32'(BURST_MAX);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [LEN_WIDTH-1:0]     remain_q, remain_d;
  logic [CNT_W-1:0]         inflight_q, inflight_d;
  logic [BUFADDR_WIDTH-1:0] bidx_q, bidx_d;
  logic [BUFADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     we_q, we_d;
  logic                     err_q, err_d;

  logic [8:0] beats;
  logic       ar_valid, ar_hs, r_hs, r_last_hs;
  logic       unused_rid;

  assign unused_rid = ^m_axi.rid;

  // Beats of the next burst. Derived only from registered state, so the
  // AR payload cannot move while a request waits for arready.
  always_comb begin
    beats = 9'(BURST_MAX);
    if (32'(remain_q) < BURST_CAP) beats = 9'(remain_q);
`ifdef NINJIN_RD_4K_SPLIT_EN
    begin : split_4k
      logic [12:0] room;
      room = (13'd4096 - {1'b0, addr_q[11:0]}) >> SIZE;
      if (32'(room) < 32'(beats)) beats = 9'(room);
    end
`endif
  end

  assign ar_valid  = (state_q == RUN) && (remain_q != '0) && (inflight_q < MAX_INFL);
  assign ar_hs     = ar_valid && m_axi.arready;
  assign r_hs      = m_axi.rvalid && (state_q == RUN);
  // A stray last beat with nothing in flight must not wrap the counter.
  assign r_last_hs = r_hs && m_axi.rlast && (inflight_q != '0);

  // AR fields are zeroed while idle so the port reads all-zero in reset.
  assign m_axi.arvalid = ar_valid;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = ar_valid ? 8'(beats - 9'd1) : 8'd0;
  assign m_axi.arsize  = ar_valid ? 3'(SIZE) : 3'd0;
  assign m_axi.arburst = ar_valid ? 2'b01 : 2'b00;
  assign m_axi.arcache = ar_valid ? 4'b0011 : 4'b0000;
  assign m_axi.arid    = '0;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arprot  = 3'd0;
  assign m_axi.arqos   = 4'd0;
  assign m_axi.rready  = (state_q == RUN);

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign err       = err_q;
  assign buf_we    = we_q;
  assign buf_addr  = waddr_q;
  assign buf_wdata = wdata_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    inflight_d = inflight_q;
    bidx_d     = bidx_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d     = base_addr;
          remain_d   = total_len;
          bidx_d     = buf_base;
          inflight_d = '0;
          err_d      = 1'b0;
          state_d    = (total_len == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (ar_hs) begin
          addr_d   = addr_q + (ADDR_WIDTH'(beats) << SIZE);
          remain_d = remain_q - LEN_WIDTH'(beats);
        end
        if (ar_hs && !r_last_hs)      inflight_d = inflight_q + 1'b1;
        else if (!ar_hs && r_last_hs) inflight_d = inflight_q - 1'b1;
        if (r_hs) begin
          we_d    = 1'b1;
          wdata_d = m_axi.rdata;
          waddr_d = bidx_q;
          bidx_d  = bidx_q + 1'b1;
          if (m_axi.rresp != 2'b00 || inflight_q == '0) err_d = 1'b1;
        end
        // The final beat's buffer write is visible in this same cycle, as
        // the in-flight count reaches zero on the edge that registers it.
        if (remain_q == '0 && inflight_q == '0) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      inflight_q <= '0;
      bidx_q     <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      inflight_q <= inflight_d;
      bidx_q     <= bidx_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_ninjin_axi_rd_dma.sv
// tb_ninjin_axi_rd_dma
// Bench for ninjin_axi_rd_dma. A transfer-level model (list of expected
// bursts plus expected buffer writes derived from base address and beat
// index) is checked against the DUT every cycle by one compare process,
// which also plays the AXI slave. Directed transfers cover the main
// scenarios; a few literal expectations pin the burst model.
`timescale 1ns/1ps
module tb_ninjin_axi_rd_dma;
  localparam int ID_WIDTH      = 1;
  localparam int DATA_WIDTH    = 32;
  localparam int ADDR_WIDTH    = 32;
  localparam int BURST_MAX     = 256;
  localparam int LEN_WIDTH     = 16;
  localparam int BUFADDR_WIDTH = 12;
  localparam int OUTSTANDING   = 2;
  localparam logic [31:0] DATA_KEY = 32'hC0DE_0000;

  typedef struct {
    logic [31:0] addr;
    int          len;
  } burst_t;

  logic        clk = 1'b0;
  logic        xrst = 1'b0;
  logic        startReq = 1'b0;
  logic [31:0] baseAddr = '0;
  logic [15:0] totalLen = '0;
  logic [11:0] bufBaseAddr = '0;
  logic        busyOut, doneOut, errOut, bufWe;
  logic [11:0] bufAddr;
  logic [31:0] bufWdata;

  ninjin_axi_rd_dma_if #(.ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) axiIf ();

  ninjin_axi_rd_dma #(
    .ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .BURST_MAX(BURST_MAX), .LEN_WIDTH(LEN_WIDTH), .BUFADDR_WIDTH(BUFADDR_WIDTH),
    .OUTSTANDING(OUTSTANDING)
  ) dut (
    .clk(clk), .xrst(xrst), .start(startReq), .base_addr(baseAddr),
    .total_len(totalLen), .buf_base(bufBaseAddr), .busy(busyOut),
    .done(doneOut), .err(errOut), .buf_we(bufWe), .buf_addr(bufAddr),
    .buf_wdata(bufWdata), .m_axi(axiIf.master)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;
  int cycleNo = 0;

  always @(posedge clk) cycleNo <= cycleNo + 1;

  // Model and slave state
  burst_t      expAr[$];
  burst_t      slvQ[$];
  burst_t      arEntry;
  logic        modelEn = 1'b0;
  int          slvBeat = 0, rBeatGlobal = 0, outstanding = 0, outPre = 0;
  int          maxOutstanding = 0, stallLeft = 0, rGap = 0, errBeat = -1;
  int          weCount = 0, lastWeCycle = -100, doneCount = 0;
  logic [31:0] curBase = '0;
  logic [11:0] curBufBase = '0;
  logic        pendWrite = 1'b0, holdValid = 1'b0, phase = 1'b0, rLastNow;
  logic [11:0] pendAddr = '0;
  logic [31:0] pendData = '0, holdAddr = '0;
  logic [7:0]  holdLen = '0;

  initial begin
    axiIf.arready = 1'b0;
    axiIf.rvalid  = 1'b0;
    axiIf.rlast   = 1'b0;
    axiIf.rresp   = 2'b00;
    axiIf.rdata   = '0;
    axiIf.rid     = '0;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Expected burst list from plain arithmetic on the transfer description.
  task automatic buildBursts(input logic [31:0] base, input int len);
    logic [31:0] a;
    int rem, beats;
    a = base;
    rem = len;
    expAr.delete();
    while (rem > 0) begin
      beats = (rem < BURST_MAX) ? rem : BURST_MAX;
`ifdef NINJIN_RD_4K_SPLIT_EN
      if ((4096 - int'(a % 4096)) / 4 < beats) beats = (4096 - int'(a % 4096)) / 4;
`endif
      expAr.push_back('{a, beats - 1});
      a += 32'(beats * 4);
      rem -= beats;
    end
  endtask

  // Compare process and AXI slave; all decisions are taken at the falling
  // edge for the handshakes that complete on the following rising edge.
  always @(negedge clk) begin
    if (!modelEn) begin
      axiIf.arready = 1'b0;
      axiIf.rvalid  = 1'b0;
      axiIf.rlast   = 1'b0;
      slvQ.delete();
      slvBeat = 0;
      outstanding = 0;
      pendWrite = 1'b0;
      holdValid = 1'b0;
    end else begin
      if (pendWrite) begin
        checkOutput("buf_we", bufWe, 1);
        checkOutput("buf_addr", bufAddr, pendAddr);
        checkOutput("buf_wdata", bufWdata, pendData);
        weCount++;
        lastWeCycle = cycleNo;
      end else begin
        checkOutput("buf_we idle", bufWe, 0);
      end
      pendWrite = 1'b0;
      if (doneOut) doneCount++;
      if (holdValid) begin
        checkOutput("arvalid held", axiIf.arvalid, 1);
        checkOutput("araddr stable", axiIf.araddr, holdAddr);
        checkOutput("arlen stable", axiIf.arlen, holdLen);
      end
      holdValid = 1'b0;
      outPre = outstanding;
      // R channel first so a burst never returns data on its own AR edge.
      phase = ~phase;
      if (slvQ.size() > 0 && (rGap == 0 || phase)) begin
        rLastNow = (slvBeat == slvQ[0].len);
        axiIf.rvalid = 1'b1;
        axiIf.rdata  = (slvQ[0].addr + 32'(slvBeat * 4)) ^ DATA_KEY;
        axiIf.rlast  = rLastNow;
        axiIf.rresp  = (rBeatGlobal == errBeat) ? 2'b10 : 2'b00;
        if (axiIf.rready) begin
          pendWrite = 1'b1;
          pendAddr  = curBufBase + 12'(rBeatGlobal);
          pendData  = (curBase + 32'(rBeatGlobal * 4)) ^ DATA_KEY;
          rBeatGlobal++;
          if (rLastNow) begin
            void'(slvQ.pop_front());
            slvBeat = 0;
            outstanding--;
          end else begin
            slvBeat++;
          end
        end
      end else begin
        axiIf.rvalid = 1'b0;
        axiIf.rlast  = 1'b0;
        axiIf.rresp  = 2'b00;
      end
      if (axiIf.arvalid && stallLeft > 0) begin
        axiIf.arready = 1'b0;
        stallLeft--;
      end else begin
        axiIf.arready = 1'b1;
      end
      if (axiIf.arvalid) begin
        if (!axiIf.arready) begin
          holdValid = 1'b1;
          holdAddr  = axiIf.araddr;
          holdLen   = axiIf.arlen;
        end else if (expAr.size() == 0) begin
          checkOutput("unexpected AR", 1, 0);
        end else begin
          arEntry = expAr.pop_front();
          checkOutput("araddr", axiIf.araddr, arEntry.addr);
          checkOutput("arlen", axiIf.arlen, 64'(arEntry.len));
          checkOutput("arsize", axiIf.arsize, 2);
          checkOutput("arburst", axiIf.arburst, 1);
          checkOutput("arcache", axiIf.arcache, 3);
          checkOutput("ar zero fields", {axiIf.arid, axiIf.arlock, axiIf.arprot, axiIf.arqos}, 0);
          checkOutput("inflight below limit", outPre < OUTSTANDING, 1);
          slvQ.push_back('{axiIf.araddr, int'(axiIf.arlen)});
          outstanding++;
        end
      end
      if (outstanding > maxOutstanding) maxOutstanding = outstanding;
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " status"}, {busyOut, doneOut, errOut, bufWe}, 0);
    checkOutput({tag, " buf_addr"}, bufAddr, 0);
    checkOutput({tag, " buf_wdata"}, bufWdata, 0);
    checkOutput({tag, " arvalid/rready"}, {axiIf.arvalid, axiIf.rready}, 0);
    checkOutput({tag, " araddr"}, axiIf.araddr, 0);
    checkOutput({tag, " ar fields"}, {axiIf.arlen, axiIf.arsize, axiIf.arburst, axiIf.arcache,
                                      axiIf.arid, axiIf.arlock, axiIf.arprot, axiIf.arqos}, 0);
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] base, input int len,
                               input logic [11:0] bufB, input int stall, input int gap,
                               input int eBeat, input logic expErr);
    int startCycle, waitCnt;
    logic seen;
    buildBursts(base, len);
    curBase = base;
    curBufBase = bufB;
    rBeatGlobal = 0;
    weCount = 0;
    doneCount = 0;
    maxOutstanding = 0;
    stallLeft = stall;
    rGap = gap;
    errBeat = eBeat;
    lastWeCycle = -100;
    @(negedge clk);
    startReq = 1'b1;
    baseAddr = base;
    totalLen = 16'(len);
    bufBaseAddr = bufB;
    startCycle = cycleNo;
    @(negedge clk);
    startReq = 1'b0;
    checkOutput({tag, " busy after start"}, busyOut, 1);
    checkOutput({tag, " err cleared on start"}, errOut, 0);
    seen = doneOut;
    waitCnt = 0;
    while (!seen && waitCnt < 5000) begin
      @(negedge clk);
      waitCnt++;
      seen = doneOut;
    end
    checkOutput({tag, " done within bound"}, seen, 1);
    if (seen) begin
      if (len == 0) checkOutput({tag, " zero-length done latency"}, 64'(cycleNo - startCycle), 1);
      else checkOutput({tag, " done one cycle after last write"}, 64'(cycleNo - lastWeCycle), 1);
      checkOutput({tag, " err at done"}, errOut, expErr);
      checkOutput({tag, " busy with done"}, busyOut, 1);
    end
    @(negedge clk);
    checkOutput({tag, " idle after done"}, {busyOut, doneOut, axiIf.arvalid}, 0);
    checkOutput({tag, " write count"}, 64'(weCount), 64'(len));
    checkOutput({tag, " done pulses"}, 64'(doneCount), 1);
    checkOutput({tag, " all bursts issued"}, 64'(expAr.size()), 0);
    checkOutput({tag, " inflight bound"}, maxOutstanding <= OUTSTANDING, 1);
  endtask

  initial begin
    #2;
    checkResetOutputs("reset");
    repeat (3) @(negedge clk);
    xrst = 1'b1;
    modelEn = 1'b1;

    // Literal pins on the burst model.
    buildBursts(32'h1000, 16);
    checkOutput("pin 16 count", 64'(expAr.size()), 1);
    checkOutput("pin 16 burst", {expAr[0].addr, 32'(expAr[0].len)}, {32'h1000, 32'd15});
    buildBursts(32'h0, 600);
    checkOutput("pin 600 count", 64'(expAr.size()), 3);
    checkOutput("pin 600 b0", {expAr[0].addr, 32'(expAr[0].len)}, {32'h000, 32'd255});
    checkOutput("pin 600 b1", {expAr[1].addr, 32'(expAr[1].len)}, {32'h400, 32'd255});
    checkOutput("pin 600 b2", {expAr[2].addr, 32'(expAr[2].len)}, {32'h800, 32'd87});
    buildBursts(32'h0FF0, 16);
`ifdef NINJIN_RD_4K_SPLIT_EN
    checkOutput("pin 4k count", 64'(expAr.size()), 2);
    checkOutput("pin 4k b0", {expAr[0].addr, 32'(expAr[0].len)}, {32'h0FF0, 32'd3});
    checkOutput("pin 4k b1", {expAr[1].addr, 32'(expAr[1].len)}, {32'h1000, 32'd11});
`else
    checkOutput("pin 4k count", 64'(expAr.size()), 1);
    checkOutput("pin 4k b0", {expAr[0].addr, 32'(expAr[0].len)}, {32'h0FF0, 32'd15});
`endif
    expAr.delete();

    applyStimulus("single", 32'h1000, 16, 12'h010, 0, 0, -1, 1'b0);
    applyStimulus("multi", 32'h0000, 600, 12'h000, 0, 0, -1, 1'b0);
    checkOutput("multi reached inflight limit", 64'(maxOutstanding), 2);
    applyStimulus("stall", 32'h2000, 40, 12'h100, 5, 1, -1, 1'b0);
    applyStimulus("4k", 32'h0FF0, 16, 12'h200, 0, 0, -1, 1'b0);
    applyStimulus("rresp", 32'h5000, 16, 12'h300, 0, 0, 5, 1'b1);
    applyStimulus("after err", 32'h6000, 4, 12'h320, 0, 0, -1, 1'b0);
    applyStimulus("zero", 32'h7000, 0, 12'h000, 0, 0, -1, 1'b0);
    applyStimulus("wrap", 32'h8000, 16, 12'hFF8, 0, 0, -1, 1'b0);

    // Asynchronous reset in the middle of a burst.
    buildBursts(32'h3000, 300);
    curBase = 32'h3000;
    curBufBase = 12'h080;
    rBeatGlobal = 0;
    stallLeft = 0;
    rGap = 0;
    errBeat = -1;
    @(negedge clk);
    startReq = 1'b1;
    baseAddr = 32'h3000;
    totalLen = 16'd300;
    bufBaseAddr = 12'h080;
    @(negedge clk);
    startReq = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("midreset busy before", busyOut, 1);
    modelEn = 1'b0;
    #2 xrst = 1'b0;
    #1 checkResetOutputs("midreset");
    repeat (3) @(negedge clk);
    expAr.delete();
    xrst = 1'b1;
    modelEn = 1'b1;
    applyStimulus("post reset", 32'h9000, 20, 12'h040, 0, 0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
